uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter in the Bluetooth link path. Adds an integrated baud generator set by parameter, configurable data width, parity and stop bits, and a valid/ready input handshake so a game-logic FIFO or CPU port can stream bytes without dropping any. Sits between the command encoder and the HC-05 module's RX pin.

Parameters:
CLKS_PER_BIT, 5208, clk_in cycles per UART bit (50 MHz / 9600 baud); legal range >= 2
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1 or 2

Ports:
clk_in  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
din  input  DATA_BITS  data word; sampled only on acceptance
din_valid  input  1  din holds a word to send
din_ready  output  1  block can accept a word (combinational: state==IDLE)
busy  output  1  high in every state except IDLE
done  output  1  one clk_in pulse at the end of each completed frame
baud_tick  output  1  one-cycle pulse on the last clk_in cycle of every bit period
tx  output  1  serial line; idle high; registered

Behaviour:
- Reset, asynchronous: tx=1, state=IDLE, bit and baud counters=0, done=0, baud_tick=0, shift register cleared. Reset mid-frame aborts the frame immediately, with no done pulse and the word discarded.
- Acceptance: a clk_in edge with din_valid && din_ready. The shift register latches din. The parity bit is computed at the same time: even = XOR of din, odd = its inverse.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE.
- Baud counter: runs only outside IDLE. Counts 0..CLKS_PER_BIT-1 and is cleared on acceptance. baud_tick=1 when count==CLKS_PER_BIT-1, and the state/bit advances on that cycle.
- Latency: tx drives the start bit (0) starting the clk_in cycle after acceptance. Every bit lasts exactly CLKS_PER_BIT cycles.
- DATA: LSB first. The bit counter runs 0..DATA_BITS-1, and DATA exits on the tick with bit counter==DATA_BITS-1.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. done=1 on the final tick of STOP, and the state returns to IDLE on the same edge.
- Back-to-back: din_valid held high gives acceptance in the first IDLE cycle. The inter-frame gap is therefore exactly 1 clk_in cycle of extra idle-high.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, from start bit to done.
- din changes after acceptance have no effect on the current frame. PARITY values 3 and above are treated as 0.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input brk (1 bit) and state BREAK.
  - In IDLE, brk=1 has priority over din_valid: the block enters BREAK and tx=0 while brk stays high. busy=1 and din_ready=0 throughout.
  - When brk falls, tx=1 for one bit time (CLKS_PER_BIT cycles), then the block returns to IDLE. No done pulse is generated.
  - brk asserted mid-frame is ignored until IDLE.
- Not defined: no brk port, no BREAK state; behaviour is exactly as above.

Test Plan:
- CLKS_PER_BIT=4, 8N1, din=0x55 pulsed valid:
  - tx = 0, 1,0,1,0,1,0,1,0, 1, each held 4 clocks.
  - done pulses exactly 40 clocks after the first start-bit cycle; busy high for those 40 clocks.
- PARITY=1, din=0x07: parity bit=1. PARITY=2, din=0x07: parity bit=0. Frame is 44 clocks.
- din_valid held with words 0xA5 then 0x3C:
  - Second acceptance happens 1 clock after done, and its start bit begins on the following clock.
  - Both bytes are reconstructed correctly by a monitor sampling at bit centres.
- reset asserted during data bit 3 of 0xFF: tx=1 and busy=0 before the next edge, no done pulse. Next word 0x12 is sent intact after reset is released.
- DATA_BITS=7, STOP_BITS=2, din=0x41: frame is 10 bits (40 clocks), with 8 idle-high clocks before done.
- UART_TX_BREAK_EN defined, brk high for 30 clocks while IDLE:
  - tx=0 for 30 clocks, then 1 for 4 clocks, then IDLE.
  - din_valid asserted during break is not accepted until IDLE.

Source files
------------

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter with integrated baud generator,
//               configurable data/parity/stop bits and a valid/ready input.
//               Optional line-break generation when UART_TX_BREAK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 din_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 baud_tick,
    output logic                 tx
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W = $clog2(DATA_BITS);
    localparam bit c_PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit c_PAR_ODD = (PARITY == 2);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
    // Value of the stop-bit counter during the final stop bit.
    localparam logic               c_STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
`ifdef UART_TX_BREAK_EN
        S_BREAK  = 3'd5,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_stop_cnt;
    logic                 r_done;
    logic                 r_tx;
`ifdef UART_TX_BREAK_EN
    logic                 r_brk_rel;
`endif
    logic                 w_tick;

    assign w_tick    = (r_state != S_IDLE) && (r_baud_cnt == c_CNT_LAST);
    assign din_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign baud_tick = w_tick;
    assign tx        = r_tx;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_done     <= 1'b0;
            r_tx       <= 1'b1;
`ifdef UART_TX_BREAK_EN
            r_brk_rel  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
`ifdef UART_TX_BREAK_EN
                    if (brk) begin
                        r_state   <= S_BREAK;
                        r_tx      <= 1'b0;
                        r_brk_rel <= 1'b0;
                    end else
`endif
                    if (din_valid) begin
                        r_shift    <= din;
                        r_par      <= c_PAR_ODD ? ~(^din) : ^din;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == c_BIT_LAST) begin
                            if (c_PAR_EN) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt == c_STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    // Hold the line low with the baud counter parked until brk falls,
                    // then send one idle-high bit time before returning to IDLE.
                    if (!r_brk_rel) begin
                        r_baud_cnt <= '0;
                        if (!brk) begin
                            r_brk_rel <= 1'b1;
                            r_tx      <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_state   <= S_IDLE;
                        r_brk_rel <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Scoreboard bench for uart_tx_param over four parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] r_valid;
    logic [7:0] r_din [4];
`ifdef UART_TX_BREAK_EN
    logic [3:0] r_brk;
`endif
    wire  [3:0] w_ready, w_busy, w_done, w_tick, w_tx;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sb_q [$];

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk_in(clk), .reset(rst), .din(r_din[0]), .din_valid(r_valid[0]),
`ifdef UART_TX_BREAK_EN
        .brk(r_brk[0]),
`endif
        .din_ready(w_ready[0]), .busy(w_busy[0]), .done(w_done[0]),
        .baud_tick(w_tick[0]), .tx(w_tx[0]));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk_in(clk), .reset(rst), .din(r_din[1]), .din_valid(r_valid[1]),
`ifdef UART_TX_BREAK_EN
        .brk(r_brk[1]),
`endif
        .din_ready(w_ready[1]), .busy(w_busy[1]), .done(w_done[1]),
        .baud_tick(w_tick[1]), .tx(w_tx[1]));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk_in(clk), .reset(rst), .din(r_din[2]), .din_valid(r_valid[2]),
`ifdef UART_TX_BREAK_EN
        .brk(r_brk[2]),
`endif
        .din_ready(w_ready[2]), .busy(w_busy[2]), .done(w_done[2]),
        .baud_tick(w_tick[2]), .tx(w_tx[2]));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk_in(clk), .reset(rst), .din(r_din[3][6:0]), .din_valid(r_valid[3]),
`ifdef UART_TX_BREAK_EN
        .brk(r_brk[3]),
`endif
        .din_ready(w_ready[3]), .busy(w_busy[3]), .done(w_done[3]),
        .baud_tick(w_tick[3]), .tx(w_tx[3]));

    // Expected line sequence, LSB first: start, data, optional parity, stops (rest idle-high).
    function automatic logic [15:0] model_frame(input logic [7:0] w, input int nd,
                                                input int par, input int ns);
        logic [15:0] f;
        logic        p;
        int          k;
        f = '1;
        f[0] = 1'b0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f[k] = w[i];
            p    = p ^ w[i];
            k++;
        end
        if (par == 1) begin f[k] = p;  k++; end
        if (par == 2) begin f[k] = ~p; k++; end
        for (int i = 0; i < ns; i++) begin f[k] = 1'b1; k++; end
        return f;
    endfunction

    task automatic send(input int idx, input logic [7:0] w, input bit push, input bit keep,
                        input int nd, input int par, input int ns);
        int wait_n;
        if (push) sb_q.push_back(model_frame(w, nd, par, ns));
        r_din[idx]   = w;
        r_valid[idx] = 1'b1;
        wait_n = 0;
        while (w_ready[idx] !== 1'b1 && wait_n < 400) begin
            @(negedge clk);
            wait_n++;
        end
        @(negedge clk);
        if (!keep) r_valid[idx] = 1'b0;
    endtask

    // Records a frame from its first start-bit cycle; ends on the cycle right after it.
    task automatic capture(input int idx, input int nbits, output logic [15:0] bits,
                           output int bad_hold, output int busy_low, output int done_early,
                           output int tick_bad, output bit timeout);
        logic [3:0] v;
        int         wait_n;
        bits = '1; bad_hold = 0; busy_low = 0; done_early = 0; tick_bad = 0; timeout = 1'b0;
        v = '0;
        wait_n = 0;
        while (w_tx[idx] !== 1'b0 && wait_n < 400) begin
            @(negedge clk);
            wait_n++;
        end
        if (w_tx[idx] !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                v[c] = w_tx[idx];
                if (w_busy[idx] !== 1'b1) busy_low++;
                if (w_done[idx] !== 1'b0) done_early++;
                if (w_tick[idx] !== (c == CPB - 1)) tick_bad++;
                @(negedge clk);
            end
            bits[b] = v[CPB/2];
            if (v != 4'h0 && v != 4'hF) bad_hold++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (w_tx !== 4'hF)    begin n_fail++; $display("FAIL reset_tx: got %b, want 1111", w_tx); end
        n_tests++; if (w_busy !== 4'h0)  begin n_fail++; $display("FAIL reset_busy: got %b, want 0000", w_busy); end
        n_tests++; if (w_done !== 4'h0)  begin n_fail++; $display("FAIL reset_done: got %b, want 0000", w_done); end
        n_tests++; if (w_tick !== 4'h0)  begin n_fail++; $display("FAIL reset_tick: got %b, want 0000", w_tick); end
        n_tests++; if (w_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b, want 1111", w_ready); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (w_tx !== 4'hF) begin n_fail++; $display("FAIL idle_tx: got %b, want 1111", w_tx); end
    endtask

    task automatic test_frame(input string name, input int idx, input int nbits);
        logic [15:0] bits, exp;
        int          hold, blow, dearly, tbad;
        bit          tmo;
        capture(idx, nbits, bits, hold, blow, dearly, tbad, tmo);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
        n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: no start bit seen", name); end
        n_tests++; if (bits !== exp) begin n_fail++; $display("FAIL %s_bits: got %b, want %b", name, bits, exp); end
        n_tests++; if ((hold | blow | dearly | tbad) !== 0) begin
            n_fail++;
            $display("FAIL %s_timing: hold=%0d busy_low=%0d done_early=%0d tick_bad=%0d, want all 0",
                     name, hold, blow, dearly, tbad);
        end
        n_tests++; if (w_done[idx] !== 1'b1 || w_busy[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b busy=%b at cycle %0d, want done=1 busy=0", name,
                     w_done[idx], w_busy[idx], nbits * CPB);
        end
    endtask

    task automatic test_8n1;
        send(0, 8'h55, 1'b1, 1'b0, 8, 0, 1);
        test_frame("8n1_55", 0, 10);
        @(negedge clk);
        n_tests++; if (w_done[0] !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b, want 0", w_done[0]); end
    endtask

    task automatic test_parity;
        send(1, 8'h07, 1'b1, 1'b0, 8, 1, 1);
        test_frame("even_07", 1, 11);
        send(2, 8'h07, 1'b1, 1'b0, 8, 2, 1);
        test_frame("odd_07", 2, 11);
        send(1, 8'hB4, 1'b1, 1'b0, 8, 1, 1);
        test_frame("even_b4", 1, 11);
    endtask

    task automatic test_back_to_back;
        send(0, 8'hA5, 1'b1, 1'b1, 8, 0, 1);
        r_din[0] = 8'h3C;
        sb_q.push_back(model_frame(8'h3C, 8, 0, 1));
        test_frame("b2b_a5", 0, 10);
        n_tests++; if (w_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b, want 1", w_ready[0]); end
        @(negedge clk);
        n_tests++; if (w_tx[0] !== 1'b0 || w_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap: tx=%b busy=%b, want tx=0 busy=1", w_tx[0], w_busy[0]);
        end
        r_valid[0] = 1'b0;
        test_frame("b2b_3c", 0, 10);
    endtask

    task automatic test_reset_midframe;
        int dpulse, txlow;
        send(0, 8'hFF, 1'b0, 1'b0, 8, 0, 1);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_abort: tx=%b busy=%b, want tx=1 busy=0", w_tx[0], w_busy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        dpulse = 0; txlow = 0;
        for (int i = 0; i < 60; i++) begin
            if (w_done[0] !== 1'b0) dpulse++;
            if (w_tx[0] !== 1'b1) txlow++;
            @(negedge clk);
        end
        n_tests++; if (dpulse != 0 || txlow != 0) begin
            n_fail++; $display("FAIL midreset_quiet: done cycles=%0d tx low cycles=%0d, want 0 and 0", dpulse, txlow);
        end
        send(0, 8'h12, 1'b1, 1'b0, 8, 0, 1);
        test_frame("after_reset_12", 0, 10);
    endtask

    task automatic test_7n2;
        send(3, 8'h41, 1'b1, 1'b0, 7, 0, 2);
        test_frame("7n2_41", 3, 10);
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break;
        int lo_err, hi_err, derr;
        lo_err = 0; hi_err = 0; derr = 0;
        r_brk[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (w_tx[0] !== 1'b0 || w_busy[0] !== 1'b1 || w_ready[0] !== 1'b0) lo_err++;
            if (w_done[0] !== 1'b0) derr++;
            if (k == 1) begin r_din[0] = 8'h5A; r_valid[0] = 1'b1; end
            if (k == 30) r_brk[0] = 1'b0;
        end
        for (int k = 31; k <= 34; k++) begin
            @(negedge clk);
            if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b1 || w_ready[0] !== 1'b0) hi_err++;
            if (w_done[0] !== 1'b0) derr++;
        end
        @(negedge clk);
        n_tests++; if (lo_err != 0) begin n_fail++; $display("FAIL break_low: %0d bad cycles, want 0", lo_err); end
        n_tests++; if (hi_err != 0) begin n_fail++; $display("FAIL break_release: %0d bad cycles, want 0", hi_err); end
        n_tests++; if (derr != 0)   begin n_fail++; $display("FAIL break_done: %0d done cycles, want 0", derr); end
        n_tests++; if (w_ready[0] !== 1'b1 || w_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL break_idle: ready=%b busy=%b, want ready=1 busy=0", w_ready[0], w_busy[0]);
        end
        sb_q.push_back(model_frame(8'h5A, 8, 0, 1));
        @(negedge clk);
        r_valid[0] = 1'b0;
        test_frame("after_break_5a", 0, 10);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        r_valid = '0;
        for (int i = 0; i < 4; i++) r_din[i] = '0;
`ifdef UART_TX_BREAK_EN
        r_brk = '0;
`endif
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_reset_midframe();
        test_7n2();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
